mvm_gen: RTL and testbench
==========================

MVM_GEN -- requirements
Module: mvm_gen

Interface
REQ-001 Parameter M, default 12: matrix rows and output vector length.
REQ-002 Parameter N, default 12: matrix columns and input vector length.
REQ-003 Parameter T, default 8: signed input word width; output width OW = 2*T.
REQ-004 Parameter P, default 1: parallel MAC lanes; P shall divide M, range 1..M.
REQ-005 Parameter SAT, default 0: 0 means wrap-around results, 1 means saturate to signed OW range.
REQ-006 clk  in  1: single clock; all state changes on rising edge.
REQ-007 reset  in  1: asynchronous, active-low reset.
REQ-008 loadMatrix  in  1: one-cycle pulse; the next M*N cycles carry matrix words, row-major.
REQ-009 loadVector  in  1: one-cycle pulse; the next N cycles carry vector words x[0..N-1].
REQ-010 start  in  1: one-cycle pulse requesting y = A*x.
REQ-011 data_in  in  T: signed operand word, sampled every cycle of a load phase.
REQ-012 busy  out  1: high from the accepted start until the last output word.
REQ-013 done  out  1: one-cycle pulse marking results ready.
REQ-014 out_valid  out  1: high on each cycle data_out carries a result word.
REQ-015 data_out  out  OW: signed result word y[j].
REQ-016 overflow  out  1: set if any y[j] of the current operation exceeded the signed OW range; held until the next accepted start.

Function
REQ-017 States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT.
REQ-018 IDLE+loadMatrix -> LOAD_A; element counter cleared; words stored on the M*N following edges; then IDLE.
REQ-019 IDLE+loadVector -> LOAD_X; N words stored; then IDLE.
REQ-020 loadMatrix and loadVector in the same cycle: loadMatrix wins; loadVector dropped.
REQ-021 Any load pulse in the same cycle as start: load wins; start dropped.
REQ-022 Load pulse during LOAD_A or LOAD_X: abort the current load, restart at element 0 of the newly selected operand; words already written stay written.
REQ-023 start outside IDLE is ignored; load pulses while busy=1 are ignored.
REQ-024 start in IDLE -> COMPUTE; busy=1 from the next cycle; overflow cleared.
REQ-025 COMPUTE: rows processed in M/P groups of P rows; each group takes N cycles; lane p accumulates row g*P+p.
REQ-026 Products are full 2*T signed; accumulator width is OW+clog2(N), so no internal wrap occurs.
REQ-027 At the end of each row: SAT=1 clamps to [-2^(OW-1), 2^(OW-1)-1]; SAT=0 keeps the low OW bits. Either mode sets overflow if the result is out of range.
REQ-028 DRAIN: 2 pipeline cycles (multiplier register, accumulator writeback).
REQ-029 done pulses exactly (M/P)*N+2 cycles after the edge that accepted start.
REQ-030 OUTPUT: on the M cycles immediately following done, out_valid=1 and data_out = y[0], y[1], ... y[M-1], in order.
REQ-031 After the y[M-1] cycle: busy=0, state IDLE.
REQ-032 start with no prior load uses the current storage contents; the result is content-defined and is not an error.
REQ-033 Repeated start without reload yields identical results.
REQ-034 Outputs outside OUTPUT: data_out holds its last value; out_valid=0.

Reset
REQ-035 reset low asynchronously forces IDLE, busy=0, done=0, out_valid=0, overflow=0, data_out=0, and clears all counters.
REQ-036 Matrix and vector storage are not reset; contents survive reset.
REQ-037 reset mid-load or mid-compute aborts the operation; no done follows.
REQ-038 Deassertion is synchronised internally; the first command is accepted on the second edge after reset rises.

Verification
REQ-039 M=N=4, T=8, P=1, SAT=0: A=identity, x=[1,-2,3,-4], start -> done 18 cycles later; outputs 1,-2,3,-4; overflow=0.
REQ-040 Same operands with P=2 -> done 10 cycles after start; identical outputs.
REQ-041 T=8, N=4, all a=-128, all x=-128, SAT=1 -> each y = 32767, overflow=1. SAT=0 -> each y = 0 (65536 mod 2^16), overflow=1.
REQ-042 loadVector pulse 2 words into a LOAD_A -> matrix load aborted; 4 vector words accepted; start then uses the partly updated A.
REQ-043 reset pulsed during COMPUTE -> no done; then start without reload -> correct y from the retained A and x.
REQ-044 1000 random load/load/start operations, M=N=12, T=8, P in {1,3,4}: every y matches a golden model; start during busy is ignored; simultaneous-pulse priority is checked.

Source files
------------

// File: rtl/mvm_gen.sv
// ============================================================================
//  Module   : mvm_gen
//  Brief    : Matrix-vector multiplier y = A*x with P parallel MAC lanes,
//             serial operand loading and serial result streaming.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mvm_gen #(
    parameter int M   = 12,
    parameter int N   = 12,
    parameter int T   = 8,
    parameter int P   = 1,
    parameter int SAT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadMatrix,
    input  logic                  loadVector,
    input  logic                  start,
    input  logic signed [T-1:0]   data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic signed [2*T-1:0] data_out,
    output logic                  overflow
);

    localparam int c_OW  = 2 * T;
    localparam int c_G   = M / P;
    localparam int c_AW  = c_OW + $clog2(N);
    localparam int c_MA  = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int c_XA  = (N > 1) ? $clog2(N) : 1;
    localparam int c_YA  = (M > 1) ? $clog2(M) : 1;
    localparam int c_EW  = $clog2(M * N + 1);
    localparam int c_KW  = $clog2(N + 1);
    localparam int c_GW  = $clog2(c_G + 1);
    localparam int c_OIW = $clog2(M + 1);

    localparam logic signed [c_AW-1:0] c_MAX = {{(c_AW-c_OW+1){1'b0}}, {(c_OW-1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_MIN = {{(c_AW-c_OW+1){1'b1}}, {(c_OW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_X  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_OUTPUT  = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_arm;
    logic [c_EW-1:0]      r_cnt;
    logic [c_KW-1:0]      r_k;
    logic [c_GW-1:0]      r_g;
    logic                 r_drain;
    logic [c_OIW-1:0]     r_oidx;

    logic signed [T-1:0]    r_mat [M*N];
    logic signed [T-1:0]    r_vec [N];
    logic signed [c_OW-1:0] r_y   [M];

    logic                   r_p1_v;
    logic                   r_p1_first;
    logic                   r_p1_last;
    logic [c_GW-1:0]        r_p1_g;
    logic signed [c_OW-1:0] r_prod [P];
    logic signed [c_AW-1:0] r_acc  [P];

    logic                   w_load_a;
    logic                   w_load_x;
    logic                   w_load;
    logic                   w_start_go;
    logic signed [T-1:0]    w_a    [P];
    logic signed [T-1:0]    w_x;
    logic signed [c_AW-1:0] w_sum  [P];
    logic signed [c_OW-1:0] w_fin  [P];
    logic [c_YA-1:0]        w_yaddr[P];
    logic [P-1:0]           w_ovf;

    // Deassertion of the async reset is retimed: commands are honoured only
    // once this flag has been set by the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_arm <= 1'b0;
        else        r_arm <= 1'b1;
    end

    assign w_load_a   = r_arm && loadMatrix;
    assign w_load_x   = r_arm && loadVector && !loadMatrix;
    assign w_load     = w_load_a || w_load_x;
    assign w_start_go = (r_state == S_IDLE) && r_arm && start && !w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_g       <= '0;
            r_drain   <= 1'b0;
            r_oidx    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD_A, S_LOAD_X: begin
                    if (w_load_a) begin
                        r_state <= S_LOAD_A;
                        r_cnt   <= '0;
                    end else if (w_load_x) begin
                        r_state <= S_LOAD_X;
                        r_cnt   <= '0;
                    end else if (r_state == S_IDLE) begin
                        if (w_start_go) begin
                            r_state <= S_COMPUTE;
                            busy    <= 1'b1;
                            r_k     <= '0;
                            r_g     <= '0;
                        end
                    end else if (r_state == S_LOAD_A) begin
                        if (r_cnt == c_EW'(M * N - 1)) r_state <= S_IDLE;
                        else                           r_cnt   <= r_cnt + 1'b1;
                    end else begin
                        if (r_cnt == c_EW'(N - 1)) r_state <= S_IDLE;
                        else                       r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (r_k == c_KW'(N - 1)) begin
                        r_k <= '0;
                        if (r_g == c_GW'(c_G - 1)) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end else begin
                            r_g <= r_g + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain) begin
                        done    <= 1'b1;
                        r_state <= S_OUTPUT;
                        r_oidx  <= '0;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (r_oidx == c_OIW'(M)) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        data_out  <= r_y[c_YA'(r_oidx)];
                        r_oidx    <= r_oidx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand fetch for the current (group, column) issue slot.
    always_comb begin
        w_x = r_vec[c_XA'(r_k)];
        for (int p = 0; p < P; p++) begin
            w_a[p] = r_mat[c_MA'((int'(r_g) * P + p) * N + int'(r_k))];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_v     <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_g     <= '0;
            for (int p = 0; p < P; p++) r_prod[p] <= '0;
        end else begin
            r_p1_v     <= (r_state == S_COMPUTE);
            r_p1_first <= (r_k == '0);
            r_p1_last  <= (r_k == c_KW'(N - 1));
            r_p1_g     <= r_g;
            for (int p = 0; p < P; p++) begin
                r_prod[p] <= c_OW'(w_a[p]) * c_OW'(w_x);
            end
        end
    end

    // Accumulate, then range-check and wrap/clamp at the last column of a row.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_sum[p]   = (r_p1_first ? {c_AW{1'b0}} : r_acc[p]) + c_AW'(r_prod[p]);
            w_ovf[p]   = (w_sum[p] > c_MAX) || (w_sum[p] < c_MIN);
            w_yaddr[p] = c_YA'(int'(r_p1_g) * P + p);
            if (w_ovf[p] && (SAT != 0))
                w_fin[p] = w_sum[p][c_AW-1] ? c_MIN[c_OW-1:0] : c_MAX[c_OW-1:0];
            else
                w_fin[p] = w_sum[p][c_OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            for (int p = 0; p < P; p++) r_acc[p] <= '0;
        end else begin
            if (r_p1_v) begin
                for (int p = 0; p < P; p++) r_acc[p] <= w_sum[p];
            end
            if (w_start_go)
                overflow <= 1'b0;
            else if (r_p1_v && r_p1_last && (|w_ovf))
                overflow <= 1'b1;
        end
    end

    // Operand and result storage deliberately carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD_A && !w_load) r_mat[c_MA'(r_cnt)] <= data_in;
        if (r_state == S_LOAD_X && !w_load) r_vec[c_XA'(r_cnt)] <= data_in;
        if (r_p1_v && r_p1_last) begin
            for (int p = 0; p < P; p++) r_y[w_yaddr[p]] <= w_fin[p];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mvm_gen.sv
// ============================================================================
//  Module   : tb_mvm_gen
//  Brief    : Directed checks of mvm_gen: P=1/SAT=0 and P=2/SAT=1 instances
//             driven in lockstep with hand-computed results.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mvm_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               loadMatrix;
    logic               loadVector;
    logic               start;
    logic signed [7:0]  data_in;

    logic               busy_a, done_a, ov_a, ovf_a;
    logic signed [15:0] dout_a;
    logic               busy_b, done_b, ov_b, ovf_b;
    logic signed [15:0] dout_b;

    mvm_gen #(.M(4), .N(4), .T(8), .P(1), .SAT(0)) u_dut_a (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .data_in(data_in), .busy(busy_a), .done(done_a),
        .out_valid(ov_a), .data_out(dout_a), .overflow(ovf_a)
    );

    mvm_gen #(.M(4), .N(4), .T(8), .P(2), .SAT(1)) u_dut_b (
        .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .data_in(data_in), .busy(busy_b), .done(done_b),
        .out_valid(ov_b), .data_out(dout_b), .overflow(ovf_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic signed [7:0]  mat_buf [16];
    logic signed [7:0]  vec_buf [4];
    logic signed [15:0] exp_a   [4];
    logic signed [15:0] exp_b   [4];
    logic               eov_a, eov_b;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_mat();
        loadMatrix = 1'b1;
        tick();
        loadMatrix = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_in = mat_buf[i];
            tick();
        end
        data_in = '0;
    endtask

    task automatic load_vec();
        loadVector = 1'b1;
        tick();
        loadVector = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = vec_buf[i];
            tick();
        end
        data_in = '0;
    endtask

    task automatic set_exp(input int a0, a1, a2, a3, b0, b1, b2, b3,
                           input logic oa, ob);
        exp_a[0] = 16'(a0); exp_a[1] = 16'(a1); exp_a[2] = 16'(a2); exp_a[3] = 16'(a3);
        exp_b[0] = 16'(b0); exp_b[1] = 16'(b1); exp_b[2] = 16'(b2); exp_b[3] = 16'(b3);
        eov_a = oa;
        eov_b = ob;
    endtask

    // Issue start and watch both instances for 40 cycles; optionally poke
    // a start and a loadMatrix while busy, both of which must be ignored.
    task automatic run(input string nm, input bit poke);
        int dat_a = -1, dat_b = -1, nd_a = 0, nd_b = 0;
        int fo_a = -1, fo_b = -1, no_a = 0, no_b = 0, lb_a = -1, lb_b = -1;
        logic signed [15:0] got_a [4];
        logic signed [15:0] got_b [4];
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, ".busy_acc_a"}, 32'(busy_a), 1);
        check({nm, ".busy_acc_b"}, 32'(busy_b), 1);
        check({nm, ".ovf_clr_a"},  32'(ovf_a), 0);
        check({nm, ".ovf_clr_b"},  32'(ovf_b), 0);
        for (int c = 1; c <= 40; c++) begin
            if (poke) begin
                if (c == 5) start = 1'b1;
                else if (c == 6) begin start = 1'b0; loadMatrix = 1'b1; data_in = 8'sd77; end
                else if (c == 7) begin loadMatrix = 1'b0; data_in = '0; end
            end
            tick();
            if (done_a) begin nd_a++; if (dat_a < 0) dat_a = c; end
            if (done_b) begin nd_b++; if (dat_b < 0) dat_b = c; end
            if (busy_a) lb_a = c;
            if (busy_b) lb_b = c;
            if (ov_a) begin if (fo_a < 0) fo_a = c; if (no_a < 4) got_a[no_a] = dout_a; no_a++; end
            if (ov_b) begin if (fo_b < 0) fo_b = c; if (no_b < 4) got_b[no_b] = dout_b; no_b++; end
        end
        check({nm, ".done_at_a"}, dat_a, 18);
        check({nm, ".done_at_b"}, dat_b, 10);
        check({nm, ".ndone_a"},   nd_a, 1);
        check({nm, ".ndone_b"},   nd_b, 1);
        check({nm, ".first_a"},   fo_a, 19);
        check({nm, ".first_b"},   fo_b, 11);
        check({nm, ".nout_a"},    no_a, 4);
        check({nm, ".nout_b"},    no_b, 4);
        check({nm, ".lastbusy_a"}, lb_a, 22);
        check({nm, ".lastbusy_b"}, lb_b, 14);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.y%0d_a", nm, i), 32'(got_a[i]), 32'(exp_a[i]));
            check($sformatf("%s.y%0d_b", nm, i), 32'(got_b[i]), 32'(exp_b[i]));
        end
        check({nm, ".ovf_a"},  32'(ovf_a), 32'(eov_a));
        check({nm, ".ovf_b"},  32'(ovf_b), 32'(eov_b));
        check({nm, ".hold_a"}, 32'(dout_a), 32'(exp_a[3]));
        check({nm, ".hold_b"}, 32'(dout_b), 32'(exp_b[3]));
    endtask

    initial begin
        int nd, no;
        reset = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0; data_in = '0;
        tick(); tick();
        check("rst.busy",  32'(busy_a | busy_b), 0);
        check("rst.done",  32'(done_a | done_b), 0);
        check("rst.valid", 32'(ov_a | ov_b), 0);
        check("rst.ovf",   32'(ovf_a | ovf_b), 0);
        check("rst.dout_a", 32'(dout_a), 0);
        check("rst.dout_b", 32'(dout_b), 0);
        reset = 1'b1;
        tick(); tick(); tick();

        // identity matrix, x = [1,-2,3,-4]
        for (int i = 0; i < 16; i++) mat_buf[i] = (i % 5 == 0) ? 8'sd1 : 8'sd0;
        vec_buf[0] = 8'sd1; vec_buf[1] = -8'sd2; vec_buf[2] = 8'sd3; vec_buf[3] = -8'sd4;
        load_mat();
        load_vec();
        set_exp(1, -2, 3, -4, 1, -2, 3, -4, 1'b0, 1'b0);
        run("ident", 1'b1);
        run("repeat", 1'b0);

        // extreme operands: 4 * (-128 * -128) = 65536
        for (int i = 0; i < 16; i++) mat_buf[i] = -8'sd128;
        for (int i = 0; i < 4; i++)  vec_buf[i] = -8'sd128;
        load_mat();
        load_vec();
        set_exp(0, 0, 0, 0, 32767, 32767, 32767, 32767, 1'b1, 1'b1);
        run("extreme", 1'b0);
        tick(); tick(); tick();
        check("ovf_hold_a", 32'(ovf_a), 1);
        check("ovf_hold_b", 32'(ovf_b), 1);

        // matrix load aborted after 2 words by a vector load
        loadMatrix = 1'b1; tick(); loadMatrix = 1'b0;
        data_in = 8'sd5; tick();
        data_in = 8'sd6; tick();
        loadVector = 1'b1; data_in = 8'sd99; tick(); loadVector = 1'b0;
        for (int i = 1; i <= 4; i++) begin data_in = 8'(i); tick(); end
        data_in = '0;
        set_exp(-879, -1280, -1280, -1280, -879, -1280, -1280, -1280, 1'b0, 1'b0);
        run("abort", 1'b0);

        // loadMatrix beats loadVector; loadVector beats start
        for (int i = 0; i < 16; i++) mat_buf[i] = (i % 5 == 0) ? 8'sd2 : 8'sd0;
        loadMatrix = 1'b1; loadVector = 1'b1; tick(); loadMatrix = 1'b0; loadVector = 1'b0;
        for (int i = 0; i < 16; i++) begin data_in = mat_buf[i]; tick(); end
        loadVector = 1'b1; start = 1'b1; tick(); loadVector = 1'b0; start = 1'b0;
        check("prio.nostart_a", 32'(busy_a), 0);
        check("prio.nostart_b", 32'(busy_b), 0);
        vec_buf[0] = -8'sd1; vec_buf[1] = 8'sd1; vec_buf[2] = -8'sd1; vec_buf[3] = 8'sd1;
        for (int i = 0; i < 4; i++) begin data_in = vec_buf[i]; tick(); end
        data_in = '0;
        tick();
        set_exp(-2, 2, -2, 2, -2, 2, -2, 2, 1'b0, 1'b0);
        run("prio", 1'b0);

        // reset mid-compute: no done, storage retained
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("midrst.busy", 32'(busy_a | busy_b), 0);
        tick();
        reset = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("arm.start_ignored", 32'(busy_a | busy_b), 0);
        nd = 0; no = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done_a || done_b) nd++;
            if (ov_a || ov_b) no++;
        end
        check("midrst.nodone", nd, 0);
        check("midrst.noout",  no, 0);
        run("retained", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
